// File: rtl/masked_lut_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : masked_lut_sequencer_pkg
// Brief    : Shared state encoding, default dwell parameters and helpers
//            for the masked S-box table phase scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package masked_lut_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DIVIDE  = 3'd1,
    S_ADJUST  = 3'd2,
    S_REFRESH = 3'd3,
    S_LOOKUP  = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  localparam int unsigned c_shares_default     = 5;
  localparam int unsigned c_adj_cycles_default = 2;
  localparam int unsigned c_ref_cycles_default = 1;
  localparam int unsigned c_share_w            = 3;

  // Smallest width that holds (longest dwell - 1), never below one bit.
  function automatic int unsigned f_timer_w(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > 2) ? $clog2(m) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/masked_lut_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : masked_lut_sequencer_if
// Brief    : Control handshake and phase-enable bundle of the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface masked_lut_sequencer_if
  import masked_lut_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = 8
);
  logic                 start;
  logic                 abort;
  logic [CNT_W-1:0]     num_lookups;
  logic                 divide_en;
  logic                 adjust_en;
  logic [c_share_w-1:0] adjust_sel;
  logic                 refresh_en;
  logic                 address_en;
  logic                 busy;
  logic                 done;
  logic [CNT_W-1:0]     lookups_left;

  modport master (
    output start, abort, num_lookups,
    input  divide_en, adjust_en, adjust_sel, refresh_en, address_en,
    input  busy, done, lookups_left
  );

  modport slave (
    input  start, abort, num_lookups,
    output divide_en, adjust_en, adjust_sel, refresh_en, address_en,
    output busy, done, lookups_left
  );
endinterface
`default_nettype wire

// File: rtl/masked_lut_sequencer_phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : masked_lut_sequencer_phase_timer
// Brief    : Loadable down-counter; expire is high while the count is zero.
// Revision : 1.0 - initial release
// ============================================================================
module masked_lut_sequencer_phase_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             load,
  input  wire logic [WIDTH-1:0] load_value,
  output logic                  expire
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign expire = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/masked_lut_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : masked_lut_sequencer
// Brief    : Start/busy/done phase scheduler driving the divide, adjust,
//            refresh and lookup enables of the masked S-box datapath.
// Revision : 1.0 - initial release
// ============================================================================
module masked_lut_sequencer
  import masked_lut_sequencer_pkg::*;
#(
  parameter int unsigned SHARES     = c_shares_default,
  parameter int unsigned ADJ_CYCLES = c_adj_cycles_default,
  parameter int unsigned REF_CYCLES = c_ref_cycles_default,
  parameter int unsigned CNT_W      = 8
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  masked_lut_sequencer_if.slave  bus
);

  localparam logic [2:0] ST_IDLE    = S_IDLE;
  localparam logic [2:0] ST_DIVIDE  = S_DIVIDE;
  localparam logic [2:0] ST_ADJUST  = S_ADJUST;
  localparam logic [2:0] ST_REFRESH = S_REFRESH;
  localparam logic [2:0] ST_LOOKUP  = S_LOOKUP;
  localparam logic [2:0] ST_DONE    = S_DONE;

  localparam int unsigned           c_timer_w    = f_timer_w(ADJ_CYCLES, REF_CYCLES);
  localparam logic [c_timer_w-1:0]  c_adj_load   = c_timer_w'(ADJ_CYCLES - 1);
  localparam logic [c_timer_w-1:0]  c_ref_load   = c_timer_w'(REF_CYCLES - 1);
  localparam logic [c_share_w-1:0]  c_last_share = c_share_w'(SHARES - 1);

  logic [2:0]           r_state;
  logic [2:0]           w_state_nxt;
  logic [c_share_w-1:0] r_share;
  logic [c_share_w-1:0] w_share_nxt;
  logic [CNT_W-1:0]     r_lookups;
  logic [CNT_W-1:0]     w_lookups_nxt;
  logic                 w_tmr_load;
  logic [c_timer_w-1:0] w_tmr_value;
  logic                 w_tmr_expire;

  logic r_divide_en;
  logic r_adjust_en;
  logic r_refresh_en;
  logic r_address_en;
  logic r_busy;
  logic r_done;

  masked_lut_sequencer_phase_timer #(
    .WIDTH (c_timer_w)
  ) u_phase_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (w_tmr_load),
    .load_value (w_tmr_value),
    .expire     (w_tmr_expire)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_share_nxt   = r_share;
    w_lookups_nxt = r_lookups;
    w_tmr_load    = 1'b0;
    w_tmr_value   = c_adj_load;

    if ((r_state != ST_IDLE) && bus.abort) begin
      w_state_nxt   = ST_IDLE;
      w_share_nxt   = '0;
      w_lookups_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start && !bus.abort) begin
            w_state_nxt   = ST_DIVIDE;
            w_lookups_nxt = bus.num_lookups;
          end
        end
        ST_DIVIDE: begin
          w_state_nxt = ST_ADJUST;
          w_share_nxt = '0;
          w_tmr_load  = 1'b1;
          w_tmr_value = c_adj_load;
        end
        ST_ADJUST: begin
          if (w_tmr_expire) begin
            if (r_share == c_last_share) begin
              w_share_nxt = '0;
              if (r_lookups == '0) begin
                w_state_nxt = ST_DONE;
              end else begin
                w_state_nxt = ST_REFRESH;
                w_tmr_load  = 1'b1;
                w_tmr_value = c_ref_load;
              end
            end else begin
              w_share_nxt = r_share + c_share_w'(1);
              w_tmr_load  = 1'b1;
              w_tmr_value = c_adj_load;
            end
          end
        end
        ST_REFRESH: begin
          if (w_tmr_expire) begin
            w_state_nxt = ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (r_lookups != '0) begin
            w_lookups_nxt = r_lookups - CNT_W'(1);
          end
          // A zero count here can only come from a corrupted state; finish cleanly.
          if (r_lookups <= CNT_W'(1)) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_REFRESH;
            w_tmr_load  = 1'b1;
            w_tmr_value = c_ref_load;
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt   = ST_IDLE;
          w_share_nxt   = '0;
          w_lookups_nxt = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_share      <= '0;
      r_lookups    <= '0;
      r_divide_en  <= 1'b0;
      r_adjust_en  <= 1'b0;
      r_refresh_en <= 1'b0;
      r_address_en <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_share      <= w_share_nxt;
      r_lookups    <= w_lookups_nxt;
      r_divide_en  <= (w_state_nxt == ST_DIVIDE);
      r_adjust_en  <= (w_state_nxt == ST_ADJUST);
      r_refresh_en <= (w_state_nxt == ST_REFRESH);
      r_address_en <= (w_state_nxt == ST_LOOKUP);
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_done       <= (w_state_nxt == ST_DONE);
    end
  end

  assign bus.divide_en    = r_divide_en;
  assign bus.adjust_en    = r_adjust_en;
  assign bus.adjust_sel   = r_share;
  assign bus.refresh_en   = r_refresh_en;
  assign bus.address_en   = r_address_en;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.lookups_left = r_lookups;

endmodule
`default_nettype wire
